// File: rtl/phy_rst_seq.sv
// rtl/phy_rst_seq.sv - round-robin PHY reset sequencer with shared assert/settle timer
module phy_rst_seq #(
  parameter int NUM_PHY       = 2,
  parameter int RST_CYCLES    = 1048576,
  parameter int SETTLE_CYCLES = 131072,
  parameter int CNT_W         = 21
) (
  input  logic               clock,
  input  logic               sys_rst,
  input  logic [NUM_PHY-1:0] soft_rst_req,
  output logic [NUM_PHY-1:0] phy_rst_n,
  output logic [NUM_PHY-1:0] phy_ready,
  output logic               all_ready,
  output logic               busy,
  output logic [2:0]         cur_ch
);

  typedef enum logic [1:0] {IDLE, ASSERT, SETTLE} state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state, state_nx;
  logic [NUM_PHY-1:0] pending, pending_nx;
  logic [NUM_PHY-1:0] ready_nx, rst_n_nx;
  logic [2:0]         ch, ch_nx, cur_ch_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [2:0]         sel, sel_hi, sel_lo;
  logic               sel_vld, hi_vld, lo_vld;
  logic               req_cur;

  // Round robin: lowest pending index above ch wins, else lowest at or below ch.
  always_comb begin
    sel_hi = '0;
    sel_lo = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int i = NUM_PHY - 1; i >= 0; i--) begin
      if (pending[i]) begin
        if (3'(i) > ch) begin
          hi_vld = 1'b1;
          sel_hi = 3'(i);
        end else begin
          lo_vld = 1'b1;
          sel_lo = 3'(i);
        end
      end
    end
    sel_vld = hi_vld | lo_vld;
    sel     = hi_vld ? sel_hi : sel_lo;
  end

  always_comb begin
    req_cur = 1'b0;
    for (int i = 0; i < NUM_PHY; i++) begin
      if (soft_rst_req[i] && (ch == 3'(i))) req_cur = 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    ch_nx      = ch;
    cnt_nx     = cnt;
    cur_ch_nx  = cur_ch;
    pending_nx = pending;
    ready_nx   = phy_ready;

    // The channel in service restarts its timer instead of re-pending.
    for (int i = 0; i < NUM_PHY; i++) begin
      if (soft_rst_req[i]) begin
        ready_nx[i] = 1'b0;
        if (!((state != IDLE) && (ch == 3'(i)))) pending_nx[i] = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (sel_vld) begin
          ch_nx     = sel;
          cur_ch_nx = sel;
          cnt_nx    = '0;
          state_nx  = ASSERT;
          for (int i = 0; i < NUM_PHY; i++) begin
            if (sel == 3'(i)) pending_nx[i] = 1'b0;
          end
        end
      end
      ASSERT: begin
        if (req_cur) begin
          cnt_nx = '0;
        end else if (cnt == RST_LAST) begin
          cnt_nx   = '0;
          state_nx = SETTLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      SETTLE: begin
        if (req_cur) begin
          cnt_nx   = '0;
          state_nx = ASSERT;
        end else if (cnt == SETTLE_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          for (int i = 0; i < NUM_PHY; i++) begin
            if (ch == 3'(i)) ready_nx[i] = 1'b1;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    for (int i = 0; i < NUM_PHY; i++) begin
      rst_n_nx[i] = ~(pending_nx[i] | ((state_nx == ASSERT) && (ch_nx == 3'(i))));
    end
  end

  always_ff @(posedge clock or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      pending   <= '1;
      ch        <= 3'(NUM_PHY - 1);
      cnt       <= '0;
      cur_ch    <= '0;
      phy_rst_n <= '0;
      phy_ready <= '0;
    end else begin
      state     <= state_nx;
      pending   <= pending_nx;
      ch        <= ch_nx;
      cnt       <= cnt_nx;
      cur_ch    <= cur_ch_nx;
      phy_rst_n <= rst_n_nx;
      phy_ready <= ready_nx;
    end
  end

  assign all_ready = &phy_ready;
  assign busy      = (state != IDLE) || (|pending);

endmodule

// File: doc/phy_rst_seq.md
# phy_rst_seq

Parametrised PHY reset sequencer that replaces the single fixed 10 ms cold-reset counter in the board top level. It drives an active-low reset to `NUM_PHY` Ethernet PHYs. After system reset it cold-resets every PHY. It also accepts per-channel soft-reset requests at any time. Channels are serviced one at a time, round-robin, through a single shared timer, with an assert phase followed by a settle phase before a per-channel ready flag is raised. It sits between the system clock/reset and the `phyN_rst_n` pins, and its ready flags gate the MAC/kvs logic.

## Interface
- `NUM_PHY`, 2: number of PHY channels (1..8).
- `RST_CYCLES`, 1048576: cycles `phy_rst_n[i]` is held low per service (10 ms class).
- `SETTLE_CYCLES`, 131072: cycles after release before `phy_ready[i]` asserts.
- `CNT_W`, 21: timer width; must hold max(RST_CYCLES, SETTLE_CYCLES)-1.
- `clock`  in  1  system clock; all logic on rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `soft_rst_req`  in  NUM_PHY  one-cycle-or-longer request per channel; level sampled each cycle.
- `phy_rst_n`  out  NUM_PHY  registered active-low PHY reset.
- `phy_ready`  out  NUM_PHY  registered; 1 = PHY out of reset and settled.
- `all_ready`  out  1  AND of `phy_ready`.
- `busy`  out  1  1 when state is not IDLE or any channel is pending.
- `cur_ch`  out  3  channel in service (valid while not IDLE).

## Operation
- State: `pending[NUM_PHY]`, FSM {IDLE, ASSERT, SETTLE}, `ch`, `cnt[CNT_W]`.
- Reset (async): state=IDLE, pending=all 1, ch=NUM_PHY-1, cnt=0. Outputs: phy_rst_n=all 0, phy_ready=all 0, all_ready=0, busy=1, cur_ch=0.
- `phy_rst_n[i]` is 0 whenever `pending[i]`=1, or when i==ch and the state is ASSERT. Otherwise it is 1.
- `phy_ready[i]` is cleared on the edge that samples a request for i. It is set only on SETTLE completion for i.
- IDLE: if any pending, select the first pending index strictly after `ch`, wrapping modulo NUM_PHY. Then ch <= sel, pending[sel] <= 0, cnt <= 0, go to ASSERT.
- ASSERT: cnt++. At cnt==RST_CYCLES-1: cnt <= 0, go to SETTLE, phy_rst_n[ch] <= 1. ASSERT therefore lasts exactly RST_CYCLES cycles.
- SETTLE: cnt++. At cnt==SETTLE_CYCLES-1: phy_ready[ch] <= 1, go to IDLE.
- Request rules, per channel i, evaluated every cycle:
  - i not in service: pending[i] <= 1.
  - i==ch in ASSERT: cnt <= 0 (extend). pending is not set.
  - i==ch in SETTLE: return to ASSERT, cnt <= 0, phy_rst_n[ch] <= 0. pending is not set.
  - In IDLE, a request for the channel being selected on that same edge is absorbed: pending stays 0.
  - A held request level keeps restarting or re-pending every cycle. The channel completes only after the request is released.
- Requests to multiple channels in the same cycle all set pending. They are then served in round-robin order.

## Timing
- One IDLE cycle between consecutive services. Per-channel service = 1 + RST_CYCLES + SETTLE_CYCLES cycles.
- Cold start: channel k ready at edge (k+1)·(1+RST_CYCLES+SETTLE_CYCLES), counted from the first edge after sys_rst falls.
- phy_rst_n and phy_ready update on the same edge as the FSM transition. There is no extra output pipeline stage.
- `busy` and `all_ready` are combinational from registers.
- sys_rst asserted mid-sequence: all outputs return to reset values immediately, asynchronously. The full cold sequence restarts.

## Test plan
- Cold start, NUM_PHY=3, RST=8, SETTLE=4:
  - phy_rst_n[0] rises at edge 9; phy_ready[0] at edge 13.
  - phy_rst_n[1] rises at edge 22; phy_ready[1] at edge 26.
  - phy_ready[2] at edge 39; all_ready=1 and busy=0 from edge 39.
- After all_ready, pulse soft_rst_req[1] for one cycle:
  - phy_ready[1]=0 and phy_rst_n[1]=0 on the next edge; others unaffected.
  - phy_rst_n[1] stays low exactly 9 cycles (1 IDLE + 8 ASSERT).
  - ready again 13 cycles after the request edge.
- Pulse soft_rst_req[1] at SETTLE cnt=2: phy_rst_n[1] returns to 0 on the next edge. Ready follows a further 8+4 cycles later.
- Requests to channels 0 and 2 in the same cycle, last served ch=0: channel 2 is serviced first, then channel 0.
- Assert sys_rst during channel-1 ASSERT: all phy_rst_n=0, phy_ready=0 and busy=1 without a clock edge. Release → cold start timing repeats.
- Hold soft_rst_req[0] high for 20 cycles: channel 0 never becomes ready while held. Ready appears 12 cycles after release (ASSERT restart + SETTLE).
